// File: rtl/vga_dither_out_if.sv
// Pixel, sync and blanking bundle between the video controller (master)
// and the dither output stage (slave).
interface vga_dither_out_if #(
  parameter int OUT_BITS = 2
);
  logic [7:0]          r_i;
  logic [7:0]          g_i;
  logic [7:0]          b_i;
  logic                hsync_i;
  logic                vsync_i;
  logic                hblank_i;
  logic                vblank_i;
  logic                dither_en;
  logic [OUT_BITS-1:0] r_o;
  logic [OUT_BITS-1:0] g_o;
  logic [OUT_BITS-1:0] b_o;
  logic                hsync_o;
  logic                vsync_o;

  modport master (
    output r_i, g_i, b_i, hsync_i, vsync_i, hblank_i, vblank_i, dither_en,
    input  r_o, g_o, b_o, hsync_o, vsync_o
  );

  modport slave (
    input  r_i, g_i, b_i, hsync_i, vsync_i, hblank_i, vblank_i, dither_en,
    output r_o, g_o, b_o, hsync_o, vsync_o
  );
endinterface

// File: rtl/vga_dither_out.sv
// Two-stage output pipeline: 8-bit RGB reduced to OUT_BITS per channel with a 4x4
// ordered dither, syncs re-timed to match. Define DITHER_TEMPORAL_EN to shift the
// dither pattern every frame (4-frame cycle).
module vga_dither_out #(
  parameter int   OUT_BITS  = 2,
  parameter logic HSYNC_RST = 1'b0,
  parameter logic VSYNC_RST = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  vga_dither_out_if.slave bus
);

  localparam int SHIFT = 4 - OUT_BITS;

  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] t;
    case ({row, col})
      4'd0:    t = 4'd0;
      4'd1:    t = 4'd8;
      4'd2:    t = 4'd2;
      4'd3:    t = 4'd10;
      4'd4:    t = 4'd12;
      4'd5:    t = 4'd4;
      4'd6:    t = 4'd14;
      4'd7:    t = 4'd6;
      4'd8:    t = 4'd3;
      4'd9:    t = 4'd11;
      4'd10:   t = 4'd1;
      4'd11:   t = 4'd9;
      4'd12:   t = 4'd15;
      4'd13:   t = 4'd7;
      4'd14:   t = 4'd13;
      4'd15:   t = 4'd5;
      default: t = 4'd0;
    endcase
    return t;
  endfunction

  // Threshold is pre-scaled into the discarded LSBs; the 9th bit flags saturation.
  function automatic logic [OUT_BITS-1:0] quant(input logic [7:0] v, input logic [3:0] t);
    logic [8:0]          s;
    logic [OUT_BITS-1:0] q;
    s = {1'b0, v} + ({5'd0, t} << SHIFT);
    if (s[8]) begin
      q = {OUT_BITS{1'b1}};
    end else begin
      q = s[7 -: OUT_BITS];
    end
    return q;
  endfunction

  logic [1:0]          x_cnt_q, x_cnt_d;
  logic [1:0]          y_cnt_q, y_cnt_d;
  logic                hblank_q, vblank_q;
  logic [7:0]          r_q, g_q, b_q;
  logic [3:0]          t_q, t_d;
  logic                hsync_q, vsync_q;
  logic [OUT_BITS-1:0] r_o_q, g_o_q, b_o_q;
  logic                hsync_o_q, vsync_o_q;
  logic [1:0]          row_idx, col_idx;

`ifdef DITHER_TEMPORAL_EN
  logic [1:0]          frm_q, frm_d;

  // Frame counter advances on each rising edge of vertical blanking.
  always_comb begin
    frm_d = frm_q;
    if (bus.vblank_i && !vblank_q) begin
      frm_d = frm_q + 2'd1;
    end else begin
      frm_d = frm_q;
    end
  end
`endif

  // Pixel/line position tracker; blanking forces the matching counter to 0.
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (bus.hblank_i) begin
      x_cnt_d = 2'd0;
    end else if (!bus.vblank_i) begin
      x_cnt_d = x_cnt_q + 2'd1;
    end else begin
      x_cnt_d = x_cnt_q;
    end
    if (bus.vblank_i) begin
      y_cnt_d = 2'd0;
    end else if (bus.hblank_i && !hblank_q) begin
      y_cnt_d = y_cnt_q + 2'd1;
    end else begin
      y_cnt_d = y_cnt_q;
    end
  end

  // Threshold selection for the pixel entering stage 1.
  always_comb begin
`ifdef DITHER_TEMPORAL_EN
    row_idx = y_cnt_q + {1'b0, frm_q[1]};
    col_idx = x_cnt_q + {1'b0, frm_q[0]};
`else
    row_idx = y_cnt_q;
    col_idx = x_cnt_q;
`endif
    if (bus.dither_en) begin
      t_d = bayer(row_idx, col_idx);
    end else begin
      t_d = 4'd0;
    end
  end

  // Stage 1: capture pixel, threshold, syncs and blanking; advance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q  <= 2'd0;
      y_cnt_q  <= 2'd0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      r_q      <= 8'd0;
      g_q      <= 8'd0;
      b_q      <= 8'd0;
      t_q      <= 4'd0;
      hsync_q  <= HSYNC_RST;
      vsync_q  <= VSYNC_RST;
`ifdef DITHER_TEMPORAL_EN
      frm_q    <= 2'd0;
`endif
    end else begin
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      hblank_q <= bus.hblank_i;
      vblank_q <= bus.vblank_i;
      r_q      <= bus.r_i;
      g_q      <= bus.g_i;
      b_q      <= bus.b_i;
      t_q      <= t_d;
      hsync_q  <= bus.hsync_i;
      vsync_q  <= bus.vsync_i;
`ifdef DITHER_TEMPORAL_EN
      frm_q    <= frm_d;
`endif
    end
  end

  // Stage 2: quantise, blank, and present registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_q     <= {OUT_BITS{1'b0}};
      g_o_q     <= {OUT_BITS{1'b0}};
      b_o_q     <= {OUT_BITS{1'b0}};
      hsync_o_q <= HSYNC_RST;
      vsync_o_q <= VSYNC_RST;
    end else begin
      if (hblank_q || vblank_q) begin
        r_o_q <= {OUT_BITS{1'b0}};
        g_o_q <= {OUT_BITS{1'b0}};
        b_o_q <= {OUT_BITS{1'b0}};
      end else begin
        r_o_q <= quant(r_q, t_q);
        g_o_q <= quant(g_q, t_q);
        b_o_q <= quant(b_q, t_q);
      end
      hsync_o_q <= hsync_q;
      vsync_o_q <= vsync_q;
    end
  end

  assign bus.r_o     = r_o_q;
  assign bus.g_o     = g_o_q;
  assign bus.b_o     = b_o_q;
  assign bus.hsync_o = hsync_o_q;
  assign bus.vsync_o = vsync_o_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// Self-checking bench for vga_dither_out (OUT_BITS=2): directed vector table,
// async reset mid-line, and randomized frames against a behavioural model.
module tb_vga_dither_out;

  localparam int OB = 2;

  typedef struct {
    logic          hb, vb, hs, vs, den;
    logic [7:0]    r, g, b;
    logic [OB-1:0] er, eg, eb;
    logic          ehs, evs;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t pend[$];
  vec_t tbl[19];
  vec_t idle;

  int   m_px, m_ln, m_fr;
  logic m_phb, m_pvb;
  int   bayer_tbl[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  vga_dither_out_if #(.OUT_BITS(OB)) bus ();

  vga_dither_out #(.OUT_BITS(OB), .HSYNC_RST(1'b0), .VSYNC_RST(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic hb, vb, hs, vs, den,
                              input logic [7:0] r, g, b,
                              input logic [OB-1:0] er, eg, eb);
    vec_t v;
    v.hb = hb; v.vb = vb; v.hs = hs; v.vs = vs; v.den = den;
    v.r = r; v.g = g; v.b = b;
    v.er = er; v.eg = eg; v.eb = eb;
    v.ehs = hs; v.evs = vs;
    return v;
  endfunction

  function automatic logic [OB-1:0] mq(input logic [7:0] v, input int t);
    int s;
    s = int'(v) + t * (2 ** (4 - OB));
    if (s > 255) return {OB{1'b1}};
    return OB'(s / (2 ** (8 - OB)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one pixel; outputs observed now belong to the pixel driven two steps ago.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    if (pend.size() >= 2) begin
      e = pend.pop_front();
      check(tag, {24'd0, bus.r_o, bus.g_o, bus.b_o, bus.hsync_o, bus.vsync_o},
                 {24'd0, e.er, e.eg, e.eb, e.ehs, e.evs});
    end
    bus.hblank_i  = v.hb;
    bus.vblank_i  = v.vb;
    bus.hsync_i   = v.hs;
    bus.vsync_i   = v.vs;
    bus.dither_en = v.den;
    bus.r_i = v.r;
    bus.g_i = v.g;
    bus.b_i = v.b;
    pend.push_back(v);
  endtask

  // Reference: position derived from whole-frame pixel/line/frame counts.
  task automatic model_step(input logic hb, vb, hs, vs, den,
                            input logic [7:0] r, g, b, output vec_t v);
    int row, col, t;
    row = m_ln;
    col = m_px;
`ifdef DITHER_TEMPORAL_EN
    row = row + (m_fr / 2) % 2;
    col = col + m_fr % 2;
`endif
    t = den ? bayer_tbl[(row % 4) * 4 + (col % 4)] : 0;
    if (hb || vb) v = mk(hb, vb, hs, vs, den, r, g, b, 2'd0, 2'd0, 2'd0);
    else          v = mk(hb, vb, hs, vs, den, r, g, b, mq(r, t), mq(g, t), mq(b, t));
    if (hb) m_px = 0;
    else if (!vb) m_px = m_px + 1;
    if (vb) m_ln = 0;
    else if (hb && !m_phb) m_ln = m_ln + 1;
    if (vb && !m_pvb) m_fr = m_fr + 1;
    m_phb = hb;
    m_pvb = vb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pend.delete();
    m_px = 0; m_ln = 0; m_fr = 0; m_phb = 1'b0; m_pvb = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic den;
    logic [OB-1:0] t18;

    idle = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    bus.hblank_i = 1'b0; bus.vblank_i = 1'b0; bus.hsync_i = 1'b0; bus.vsync_i = 1'b0;
    bus.dither_en = 1'b0; bus.r_i = 8'h00; bus.g_i = 8'h00; bus.b_i = 8'h00;

`ifdef DITHER_TEMPORAL_EN
    t18 = 2'd1;
`else
    t18 = 2'd0;
`endif
    tbl[0]  = mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, 2'd1, 2'd0, 2'd0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, 2'd1, 2'd0, 2'd0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 8'hC0, 8'h7F, 8'h40, 2'd3, 2'd1, 2'd1);
    tbl[5]  = mk(1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, 2'd1, 2'd0, 2'd0);
    tbl[8]  = mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, 2'd1, 2'd0, 2'd0);
    tbl[10] = mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    tbl[11] = mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 8'h00, 2'd3, 2'd0, 2'd0);
    tbl[12] = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    tbl[13] = mk(0, 0, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 2'd3, 2'd3, 2'd3);
    tbl[14] = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    tbl[15] = mk(0, 0, 0, 0, 1, 8'hFF, 8'h10, 8'hC3, 2'd3, 2'd1, 2'd3);
    tbl[16] = mk(0, 1, 0, 1, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0);
    tbl[17] = mk(1, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    tbl[18] = mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, t18, 2'd0, 2'd0);

    // Power-on asynchronous reset
    #2 rst_n = 1'b0;
    #1 check("reset_state", {24'd0, bus.r_o, bus.g_o, bus.b_o, bus.hsync_o, bus.vsync_o}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors, starting from the post-reset position (x=0, y=0)
    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("vec%0d", i));
    step(idle, "vec_flush");
    step(idle, "vec_flush");

    // Reset asserted mid-line while driving white with hsync high
    do_reset();
    v = mk(0, 0, 1, 0, 0, 8'hFF, 8'h00, 8'h00, 2'd3, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) step(v, "pre_reset");
    #2 rst_n = 1'b0;
    #1 check("async_reset", {24'd0, bus.r_o, bus.g_o, bus.b_o, bus.hsync_o, bus.vsync_o}, 32'd0);
    pend.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h00, OB'(i % 2), 2'd0, 2'd0), "post_reset_row0");
    step(idle, "post_reset_flush");
    step(idle, "post_reset_flush");

    // Randomized frames: 9 active + 3 blank pixels per line, 5 active + 2 blank lines
    do_reset();
    den = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int ln = 0; ln < 7; ln++) begin
        for (int c = 0; c < 12; c++) begin
          if ($urandom_range(7) == 0) den = ~den;
          model_step(c >= 9, ln >= 5, c == 10, ln == 6, den,
                     8'($urandom), 8'($urandom), 8'($urandom), v);
          step(v, "random");
        end
      end
    end
    step(idle, "random_flush");
    step(idle, "random_flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
